// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer RAM arbiter: priority reader, round-robin writers, starvation guard
module fb_port_arbiter #(
  parameter int COLOR_W  = 3,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 19200,
  parameter int MAX_WAIT = 8
) (
  input  logic               Clck,
  input  logic               Reset,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_gnt,
  output logic [COLOR_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               w0_req,
  input  logic [ADDR_W-1:0]  w0_addr,
  input  logic [COLOR_W-1:0] w0_data,
  output logic               w0_gnt,
  input  logic               w1_req,
  input  logic [ADDR_W-1:0]  w1_addr,
  input  logic [COLOR_W-1:0] w1_data,
  output logic               w1_gnt,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [COLOR_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]   starve_cnt;
  logic               last_w;          // 0: w0 granted last, 1: w1 granted last
  logic               rd_tag1, rd_tag2;
  logic               rd_oor1, rd_oor2;

  logic               e_rd, e_w0, e_w1, w_any, w_pick, starved;
  logic               grant_w, grant_r;
  logic [ADDR_W-1:0]  w_addr;
  logic [COLOR_W-1:0] w_data;

  always_comb begin
    e_rd    = rd_req & ~rd_gnt;
    e_w0    = w0_req & ~w0_gnt;
    e_w1    = w1_req & ~w1_gnt;
    w_any   = e_w0 | e_w1;
    // w1 wins unless w0 is also eligible and w1 had the last turn
    w_pick  = e_w1 & ~(e_w0 & last_w);
    starved = (starve_cnt == MAX_C);
    grant_w = w_any & (starved | ~e_rd);
    grant_r = e_rd & ~grant_w;
    w_addr  = w_pick ? w1_addr : w0_addr;
    w_data  = w_pick ? w1_data : w0_data;
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      rd_gnt     <= 1'b0;
      w0_gnt     <= 1'b0;
      w1_gnt     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
      last_w     <= 1'b1;
      rd_tag1    <= 1'b0;
      rd_tag2    <= 1'b0;
      rd_oor1    <= 1'b0;
      rd_oor2    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_gnt  <= grant_r;
      w0_gnt  <= grant_w & ~w_pick;
      w1_gnt  <= grant_w & w_pick;
      mem_we  <= 1'b0;
      if (grant_w) begin
        mem_addr   <= w_addr;
        mem_wdata  <= w_data;
        mem_we     <= (w_addr < DEPTH_A);
        last_w     <= w_pick;
        starve_cnt <= '0;
      end else if (grant_r) begin
        mem_addr <= rd_addr;
        // a reader win with a writer waiting implies not yet saturated
        if (w_any)
          starve_cnt <= starve_cnt + 1'b1;
      end
      rd_tag1  <= grant_r;
      rd_oor1  <= (rd_addr >= DEPTH_A);
      rd_tag2  <= rd_tag1;
      rd_oor2  <= rd_oor1;
      rd_valid <= rd_tag2;
      if (rd_tag2)
        rd_data <= rd_oor2 ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter with a registered-read RAM model
module tb_fb_port_arbiter;
  localparam int MAXW = 8;
  localparam int DEP  = 19200;

  logic        Clck = 1'b0;
  logic        Reset;
  logic        rd_req, w0_req, w1_req;
  logic [14:0] rd_addr, w0_addr, w1_addr;
  logic [2:0]  w0_data, w1_data;
  logic        rd_gnt, w0_gnt, w1_gnt, rd_valid, mem_we;
  logic [2:0]  rd_data, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;

  logic [2:0] ram [0:32767];

  fb_port_arbiter #(.COLOR_W(3), .ADDR_W(15), .DEPTH(DEP), .MAX_WAIT(MAXW)) dut (
    .Clck(Clck), .Reset(Reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 Clck = ~Clck;

  always @(posedge Clck) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [2:0]  gnt;
    logic        we;
    logic [14:0] addr;
    logic [2:0]  wdata;
    logic        rv;
    logic [2:0]  rdata;
    int          cnt;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference state: what the outputs should be after the coming edge
  logic        m_rg, m_g0, m_g1, m_we, m_last, m_t1, m_t2, m_rv;
  logic [14:0] m_addr;
  logic [2:0]  m_wdata, m_d1, m_d2, m_rd;
  int          m_cnt;

  task automatic model_edge();
    bit er, e0, e1;
    int who;
    if (!Reset) begin
      {m_rg, m_g0, m_g1, m_we, m_t1, m_t2, m_rv} = '0;
      m_addr = '0; m_wdata = '0; m_d1 = '0; m_d2 = '0; m_rd = '0;
      m_cnt = 0; m_last = 1'b1;
      return;
    end
    er = rd_req && !m_rg;
    e0 = w0_req && !m_g0;
    e1 = w1_req && !m_g1;
    if (e0 && e1) who = m_last ? 1 : 2;
    else if (e0)  who = 1;
    else if (e1)  who = 2;
    else          who = 0;
    m_rv = m_t2;
    if (m_t2) m_rd = m_d2;
    m_t2 = m_t1; m_d2 = m_d1;
    m_t1 = 1'b0; m_rg = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; m_we = 1'b0;
    if (who != 0 && (m_cnt == MAXW || !er)) begin
      m_g0 = (who == 1); m_g1 = (who == 2);
      m_addr  = (who == 1) ? w0_addr : w1_addr;
      m_wdata = (who == 1) ? w0_data : w1_data;
      m_we    = (int'(m_addr) < DEP);
      m_last  = (who == 2);
      m_cnt   = 0;
    end else if (er) begin
      m_rg = 1'b1; m_t1 = 1'b1;
      m_addr = rd_addr;
      m_d1 = (int'(rd_addr) < DEP) ? ram[rd_addr] : 3'b000;
      if (who != 0 && m_cnt < MAXW) m_cnt++;
    end
  endtask

  task automatic step(input logic rst, input logic rr, input logic [14:0] ra,
                      input logic q0, input logic [14:0] a0, input logic [2:0] d0,
                      input logic q1, input logic [14:0] a1, input logic [2:0] d1);
    exp_t e, x;
    Reset = rst; rd_req = rr; rd_addr = ra;
    w0_req = q0; w0_addr = a0; w0_data = d0;
    w1_req = q1; w1_addr = a1; w1_data = d1;
    model_edge();
    e.gnt = {m_rg, m_g0, m_g1}; e.we = m_we; e.addr = m_addr; e.wdata = m_wdata;
    e.rv = m_rv; e.rdata = m_rd; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge Clck);
    @(negedge Clck);
    x = sb.pop_front();
    check("gnt", int'({rd_gnt, w0_gnt, w1_gnt}), int'(x.gnt));
    check("onehot", ($countones({rd_gnt, w0_gnt, w1_gnt}) <= 1) ? 1 : 0, 1);
    check("mem_we", int'(mem_we), int'(x.we));
    check("mem_addr", int'(mem_addr), int'(x.addr));
    if (x.gnt[1] || x.gnt[0]) check("mem_wdata", int'(mem_wdata), int'(x.wdata));
    check("rd_valid", int'(rd_valid), int'(x.rv));
    if (x.rv || !rst) check("rd_data", int'(rd_data), int'(x.rdata));
    check("starve_cnt", int'(dut.starve_cnt), x.cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 15'd0, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 3'(i);
    ram[5] = 3'b101;
    ram[19999] = 3'b110;
    Reset = 1'b0;
    {rd_req, w0_req, w1_req} = '0;
    {rd_addr, w0_addr, w1_addr} = '0;
    {w0_data, w1_data} = '0;

    // reset: all outputs zero
    for (int i = 0; i < 3; i++) step(0, 1, 15'd7, 1, 15'd8, 3'd1, 1, 15'd9, 3'd2);

    // lone read of address 5
    step(1, 1, 15'd5, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
    idle(4);
    check("ram5_returned", int'(rd_data), 5);

    // two writers continuously, no reader
    for (int i = 0; i < 8; i++) step(1, 0, 15'd0, 1, 15'(100 + i), 3'd3, 1, 15'(200 + i), 3'd4);
    idle(2);
    check("ram_w0_written", int'(ram[100]), 3);

    // reader held against w0
    for (int i = 0; i < 14; i++) step(1, 1, 15'(40 + i), 1, 15'(300 + i), 3'd6, 0, 15'd0, 3'd0);
    idle(3);

    // out-of-range write and read
    step(1, 0, 15'd0, 1, 15'd19200, 3'b111, 0, 15'd0, 3'd0);
    idle(1);
    step(1, 1, 15'd19999, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
    idle(4);

    // read in flight killed by a one-cycle reset, then w0/w1 tie
    step(1, 1, 15'd5, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
    step(0, 0, 15'd0, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 15'd0, 1, 15'd400, 3'd1, 1, 15'd500, 3'd2);
    idle(3);

    // all three from reset: rd, w0, rd, w1
    step(0, 0, 15'd0, 0, 15'd0, 3'd0, 0, 15'd0, 3'd0);
    for (int i = 0; i < 10; i++) step(1, 1, 15'd5, 1, 15'd600, 3'd5, 1, 15'd700, 3'd6);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
